// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for one DDS channel.
// In IDLE it forwards CPU-written frequency words. On start it steps the word
// from a start to a stop value with a programmable dwell, in single, sawtooth or
// triangle mode. Everything runs in the DDS clock domain; all outputs are registered.
//
// Handshake: there is no back-pressure. f_word_vld is a one-cycle pulse in the
// cycle f_word_out takes a new value; done and cfg_err are one-cycle pulses;
// busy is high exactly while the sequencer is in RUN (it doubles as the state flag).
module dds_sweep_ctrl #(
    parameter int FW_W    = 32,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FW_W-1:0]    manual_fw,
    input  logic               manual_wr,
    input  logic [FW_W-1:0]    cfg_start_fw,
    input  logic [FW_W-1:0]    cfg_stop_fw,
    input  logic [FW_W-1:0]    cfg_step_fw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    output logic [FW_W-1:0]    f_word_out,
    output logic               f_word_vld,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               dir_down
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SAW = 2'd1;
    localparam logic [1:0] MODE_TRI = 2'd2;
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [FW_W-1:0]    f_word_q, f_word_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               dir_down_q, dir_down_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Shadow copies of the sweep configuration, frozen at start.
    logic [FW_W-1:0]    sh_start_q, sh_start_d;
    logic [FW_W-1:0]    sh_stop_q, sh_stop_d;
    logic [FW_W-1:0]    sh_step_q, sh_step_d;
    logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d;
    logic [1:0]         sh_mode_q, sh_mode_d;

    logic [FW_W:0]      up_sum;
    logic [FW_W-1:0]    dn_diff;
    logic               up_ok;
    logic               dn_ok;
    logic               cfg_bad;

    // Candidate next words; the extra sum bit catches wrap past all-ones.
    always_comb begin
        up_sum  = {1'b0, f_word_q} + {1'b0, sh_step_q};
        dn_diff = f_word_q - sh_step_q;
        up_ok   = !up_sum[FW_W] && (up_sum[FW_W-1:0] <= sh_stop_q);
        dn_ok   = (f_word_q >= sh_step_q) && (dn_diff >= sh_start_q);
        cfg_bad = (cfg_step_fw == '0) || (cfg_start_fw > cfg_stop_fw);
    end

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_d    = state_q;
        f_word_d   = f_word_q;
        vld_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        dir_down_d = dir_down_q;
        cnt_d      = cnt_q;
        sh_start_d = sh_start_q;
        sh_stop_d  = sh_stop_q;
        sh_step_d  = sh_step_q;
        sh_dwell_d = sh_dwell_q;
        sh_mode_d  = sh_mode_q;

        if (abort) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            dir_down_d = 1'b0;
            f_word_d   = manual_fw;
            vld_d      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sh_start_d = cfg_start_fw;
                        sh_stop_d  = cfg_stop_fw;
                        sh_step_d  = cfg_step_fw;
                        sh_dwell_d = cfg_dwell;
                        sh_mode_d  = cfg_mode;
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d    = ST_RUN;
                            f_word_d   = cfg_start_fw;
                            vld_d      = 1'b1;
                            busy_d     = 1'b1;
                            dir_down_d = 1'b0;
                            cnt_d      = cfg_dwell;
                        end
                    end else if (manual_wr) begin
                        f_word_d = manual_fw;
                        vld_d    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_ONE;
                    end else begin
                        cnt_d = sh_dwell_q;
                        case (sh_mode_q)
                            MODE_SAW: begin
                                // Past the stop word the sawtooth restarts from the start word.
                                f_word_d = up_ok ? up_sum[FW_W-1:0] : sh_start_q;
                                vld_d    = 1'b1;
                            end
                            MODE_TRI: begin
                                // At a turn point reverse and take the first step the other way.
                                if (!dir_down_q) begin
                                    if (up_ok) begin
                                        f_word_d = up_sum[FW_W-1:0];
                                        vld_d    = 1'b1;
                                    end else begin
                                        dir_down_d = 1'b1;
                                        if (dn_ok) begin
                                            f_word_d = dn_diff;
                                            vld_d    = 1'b1;
                                        end
                                    end
                                end else begin
                                    if (dn_ok) begin
                                        f_word_d = dn_diff;
                                        vld_d    = 1'b1;
                                    end else begin
                                        dir_down_d = 1'b0;
                                        if (up_ok) begin
                                            f_word_d = up_sum[FW_W-1:0];
                                            vld_d    = 1'b1;
                                        end
                                    end
                                end
                            end
                            default: begin
                                // Single sweep (mode 0, and reserved mode 3).
                                if (up_ok) begin
                                    f_word_d = up_sum[FW_W-1:0];
                                    vld_d    = 1'b1;
                                end else begin
                                    done_d  = 1'b1;
                                    busy_d  = 1'b0;
                                    state_d = ST_IDLE;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output, counter and shadow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_word_q   <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            dir_down_q <= 1'b0;
            cnt_q      <= '0;
            sh_start_q <= '0;
            sh_stop_q  <= '0;
            sh_step_q  <= '0;
            sh_dwell_q <= '0;
            sh_mode_q  <= '0;
        end else begin
            f_word_q   <= f_word_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            dir_down_q <= dir_down_d;
            cnt_q      <= cnt_d;
            sh_start_q <= sh_start_d;
            sh_stop_q  <= sh_stop_d;
            sh_step_q  <= sh_step_d;
            sh_dwell_q <= sh_dwell_d;
            sh_mode_q  <= sh_mode_d;
        end
    end

    assign f_word_out = f_word_q;
    assign f_word_vld = vld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign dir_down   = dir_down_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: stimulus tasks push the expected output events
// (cycle, pulse flags, busy, direction, word) into a queue; a monitor pops
// and compares on every vld/done/cfg_err pulse.
module tb_dds_sweep_ctrl;

    localparam int FW_W    = 32;
    localparam int DWELL_W = 24;
    localparam int EW      = 53;

    logic               clk = 1'b0;
    logic               rst;
    logic [FW_W-1:0]    manual_fw;
    logic               manual_wr;
    logic [FW_W-1:0]    cfg_start_fw;
    logic [FW_W-1:0]    cfg_stop_fw;
    logic [FW_W-1:0]    cfg_step_fw;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic [FW_W-1:0]    f_word_out;
    logic               f_word_vld;
    logic               busy;
    logic               done;
    logic               cfg_err;
    logic               dir_down;

    dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst),
        .manual_fw(manual_fw), .manual_wr(manual_wr),
        .cfg_start_fw(cfg_start_fw), .cfg_stop_fw(cfg_stop_fw),
        .cfg_step_fw(cfg_step_fw), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .abort(abort),
        .f_word_out(f_word_out), .f_word_vld(f_word_vld), .busy(busy),
        .done(done), .cfg_err(cfg_err), .dir_down(dir_down)
    );

    // ---------------- clock / cycle counter ----------------
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [FW_W-1:0] cur_out = '0;

    function automatic logic [EW-1:0] mk_ev(input int t, input bit v, input bit d,
                                            input bit e, input bit b, input bit dn,
                                            input logic [FW_W-1:0] f);
        logic [15:0] tt;
        tt = t[15:0];
        return {tt, v, d, e, b, dn, f};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] mon_act, mon_exp;
    always @(negedge clk) begin
        if (!rst && (f_word_vld || done || cfg_err)) begin
            mon_act = mk_ev(cyc, f_word_vld, done, cfg_err, busy, dir_down, f_word_out);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got cyc=%0d vld=%0b done=%0b err=%0b busy=%0b dir=%0b fw=%h, required no event",
                         cyc, f_word_vld, done, cfg_err, busy, dir_down, f_word_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL event: got {cyc,vld,done,err,busy,dir,fw}=%h, required %h", mon_act, mon_exp);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Builds the full event list for one sweep started at edge k and aborted at
    // edge a. end_t is the edge after which the block is back in IDLE.
    task automatic model_sweep(input logic [FW_W-1:0] s, input logic [FW_W-1:0] e,
                               input logic [FW_W-1:0] st, input int dw, input int md,
                               input int k, input int a, output int end_t);
        longint cur, ls, le, lst;
        bit down;
        int p;
        ls = s; le = e; lst = st;
        end_t = 32'h7fffffff;
        if (lst == 0 || ls > le) begin
            exp_q.push_back(mk_ev(k, 0, 0, 1, 0, 0, cur_out));
            end_t = k;
            return;
        end
        cur  = ls;
        down = 0;
        p    = dw + 1;
        exp_q.push_back(mk_ev(k, 1, 0, 0, 1, 0, s));
        for (int t = k + p; t < a; t += p) begin
            if (md == 1) begin
                cur = (cur + lst <= le) ? cur + lst : ls;
                exp_q.push_back(mk_ev(t, 1, 0, 0, 1, 0, cur[31:0]));
            end else if (md == 2) begin
                if (!down) begin
                    if (cur + lst <= le) begin
                        cur += lst;
                        exp_q.push_back(mk_ev(t, 1, 0, 0, 1, 0, cur[31:0]));
                    end else begin
                        down = 1;
                        if (cur - lst >= ls) begin
                            cur -= lst;
                            exp_q.push_back(mk_ev(t, 1, 0, 0, 1, 1, cur[31:0]));
                        end
                    end
                end else begin
                    if (cur - lst >= ls) begin
                        cur -= lst;
                        exp_q.push_back(mk_ev(t, 1, 0, 0, 1, 1, cur[31:0]));
                    end else begin
                        down = 0;
                        if (cur + lst <= le) begin
                            cur += lst;
                            exp_q.push_back(mk_ev(t, 1, 0, 0, 1, 0, cur[31:0]));
                        end
                    end
                end
            end else begin
                if (cur + lst <= le) begin
                    cur += lst;
                    exp_q.push_back(mk_ev(t, 1, 0, 0, 1, 0, cur[31:0]));
                end else begin
                    exp_q.push_back(mk_ev(t, 0, 1, 0, 0, 0, cur[31:0]));
                    end_t = t;
                    break;
                end
            end
        end
        cur_out = cur[31:0];
    endtask

    // ---------------- driver tasks ----------------
    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_manual(input logic [FW_W-1:0] v);
        @(negedge clk);
        manual_fw = v;
        manual_wr = 1'b1;
        exp_q.push_back(mk_ev(cyc + 1, 1, 0, 0, 0, 0, v));
        cur_out = v;
        @(negedge clk);
        manual_wr = 1'b0;
        drain();
    endtask

    // flags[0]: start asserted together with abort; flags[1]: manual_wr with start.
    task automatic run_sweep(input logic [FW_W-1:0] s, input logic [FW_W-1:0] e,
                             input logic [FW_W-1:0] st, input int dw, input int md,
                             input int dur, input logic [1:0] flags);
        int k, a, m, end_t;
        logic [FW_W-1:0] mv;
        @(negedge clk);
        cfg_start_fw = s; cfg_stop_fw = e; cfg_step_fw = st;
        cfg_dwell = dw[DWELL_W-1:0]; cfg_mode = md[1:0];
        start = 1'b1;
        if (flags[1]) begin
            manual_wr = 1'b1;
            manual_fw = $urandom;
        end
        k = cyc + 1;
        a = k + dur;
        model_sweep(s, e, st, dw, md, k, a, end_t);
        @(negedge clk);
        start = 1'b0;
        manual_wr = 1'b0;
        // Configuration changes mid-sweep must have no effect.
        cfg_start_fw = $urandom; cfg_stop_fw = $urandom; cfg_step_fw = $urandom;
        cfg_dwell = DWELL_W'($urandom_range(0, 7)); cfg_mode = 2'($urandom_range(0, 3));
        // A manual write while running must be ignored.
        m = k + 1 + $urandom_range(0, dur - 3);
        if (m < end_t) begin
            while (cyc < m - 1) @(negedge clk);
            manual_fw = $urandom;
            manual_wr = 1'b1;
            @(negedge clk);
            manual_wr = 1'b0;
        end
        while (cyc < a - 1) @(negedge clk);
        mv = $urandom;
        manual_fw = mv;
        abort = 1'b1;
        if (flags[0]) start = 1'b1;
        exp_q.push_back(mk_ev(a, 1, 0, 0, 0, 0, mv));
        cur_out = mv;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        drain();
    endtask

    task automatic reset_mid_sweep();
        int k, end_t;
        @(negedge clk);
        cfg_start_fw = 32'd1000; cfg_stop_fw = 32'd5000; cfg_step_fw = 32'd7;
        cfg_dwell = 24'd5; cfg_mode = 2'd1;
        start = 1'b1;
        k = cyc + 1;
        model_sweep(32'd1000, 32'd5000, 32'd7, 5, 1, k, k + 2000, end_t);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_reset: got %0b, required 1", busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({f_word_out, f_word_vld, busy, done, cfg_err, dir_down} !== '0) begin
            failures++;
            $display("FAIL async_reset: got fw=%h vld=%0b busy=%0b done=%0b err=%0b dir=%0b, required all 0",
                     f_word_out, f_word_vld, busy, done, cfg_err, dir_down);
        end
        exp_q.delete();
        cur_out = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [FW_W-1:0] rs, re, rst_step;
        longint tmp;
        rst = 1'b1;
        manual_fw = '0; manual_wr = 1'b0;
        cfg_start_fw = '0; cfg_stop_fw = '0; cfg_step_fw = '0;
        cfg_dwell = '0; cfg_mode = '0;
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({f_word_out, f_word_vld, busy, done, cfg_err, dir_down} !== '0) begin
            failures++;
            $display("FAIL reset_state: got fw=%h vld=%0b busy=%0b done=%0b err=%0b dir=%0b, required all 0",
                     f_word_out, f_word_vld, busy, done, cfg_err, dir_down);
        end
        rst = 1'b0;

        do_manual(32'h1000);
        run_sweep(32'd100, 32'd130, 32'd10, 3, 0, 30, 2'b00);
        run_sweep(32'd0, 32'd20, 32'd10, 0, 2, 12, 2'b00);
        run_sweep(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h10, 1, 1, 12, 2'b00);
        run_sweep(32'd5, 32'd100, 32'd0, 2, 0, 5, 2'b00);
        run_sweep(32'd50, 32'd40, 32'd5, 2, 0, 5, 2'b00);
        run_sweep(32'd200, 32'd400, 32'd10, 2, 1, 9, 2'b01);
        run_sweep(32'd10, 32'd60, 32'd20, 1, 3, 14, 2'b10);
        run_sweep(32'd30, 32'd30, 32'd5, 0, 2, 6, 2'b11);
        do_manual(32'hCAFE_0001);
        reset_mid_sweep();
        do_manual(32'h0000_0042);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) rs = 32'hFFFFFF00 + $urandom_range(0, 200);
            else rs = $urandom_range(0, 300);
            tmp = longint'(rs) + $urandom_range(0, 120);
            if (tmp > 64'h0000_0000_FFFF_FFFF) tmp = 64'h0000_0000_FFFF_FFFF;
            re = tmp[31:0];
            if ($urandom_range(0, 7) == 0 && rs != 0) re = rs - 1;
            rst_step = $urandom_range(0, 40);
            run_sweep(rs, re, rst_step, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(3, 60), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
